// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - round-robin arbiter sharing one single-port memory between requesters
//
// Purpose:
//   N_REQ requesters share one SRAM-style port (req/we/be/addr/wdata/rdata).
//   Grant is combinational, in the same cycle as the request. The winner is the
//   first asserted request at or above prio_q, wrapping from N_REQ-1 to 0.
//   prio_q moves one past the winner after each grant, so every requester
//   is served within N_REQ cycles. The read data of a granted read returns
//   MEM_LATENCY cycles later. It is steered back to its issuer through a
//   shift register of {valid, id}.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i/we_i           per-requester request and write enable
//   be_i/addr_i/wdata_i  per-requester byte enables, address and write data (flattened)
//   gnt_o                one-hot grant
//   rvalid_o             one-hot read-data valid
//   rdata_o              shared read data (mem_rdata_i passed through)
//   mem_*_o              memory request, write enable, byte enables, address, write data
//   mem_rdata_i          memory read data
//
// Optional feature, macro MEM_ARB_PERF_CNT_EN:
//   cnt_clear_i          synchronous clear of all counters (wins over increment)
//   grant_cnt_o          per-requester saturating grant counters, 32 bits each
//   stall_cnt_o          saturating count of cycles where any request was left waiting

module mem_rr_arbiter #(
    parameter int N_REQ       = 3,
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int MEM_LATENCY = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [N_REQ-1:0]             req_i,
    input  logic [N_REQ-1:0]             we_i,
    input  logic [N_REQ*DATA_WIDTH/8-1:0] be_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0]  addr_i,
    input  logic [N_REQ*DATA_WIDTH-1:0]  wdata_i,
    output logic [N_REQ-1:0]             gnt_o,
    output logic [N_REQ-1:0]             rvalid_o,
    output logic [DATA_WIDTH-1:0]        rdata_o,
    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [DATA_WIDTH/8-1:0]      mem_be_o,
    output logic [ADDR_WIDTH-1:0]        mem_addr_o,
    output logic [DATA_WIDTH-1:0]        mem_wdata_o,
`ifdef MEM_ARB_PERF_CNT_EN
    input  logic                         cnt_clear_i,
    output logic [N_REQ*32-1:0]          grant_cnt_o,
    output logic [31:0]                  stall_cnt_o,
`endif
    input  logic [DATA_WIDTH-1:0]        mem_rdata_i
);

    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int PRIO_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PRIO_W-1:0] prio_q;
    logic [N_REQ-1:0]  prio_mask;
    logic [N_REQ-1:0]  req_hi;
    logic              found_hi;
    logic              found_any;
    logic [PRIO_W-1:0] idx_hi;
    logic [PRIO_W-1:0] idx_any;
    logic [PRIO_W-1:0] winner;
    logic              active;

    // Two-level priority search: requests at or above prio_q win first,
    // otherwise the lowest request overall wins (the wrapped part of the scan).
    always_comb begin
        prio_mask = '0;
        found_hi  = 1'b0;
        found_any = 1'b0;
        idx_hi    = '0;
        idx_any   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i >= int'(prio_q)) begin
                prio_mask[i] = 1'b1;
            end
        end
        req_hi = req_i & prio_mask;
        // Scanning downward leaves the lowest set index in idx_*.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_hi[i]) begin
                found_hi = 1'b1;
                idx_hi   = PRIO_W'(i);
            end
            if (req_i[i]) begin
                found_any = 1'b1;
                idx_any   = PRIO_W'(i);
            end
        end
    end

    assign winner = found_hi ? idx_hi : idx_any;
    // Reset masks the combinational grant path so nothing reaches memory while held.
    assign active = rst_ni & found_any;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            gnt_o[i] = active & (winner == PRIO_W'(i));
        end
    end

    // AND-OR mux keyed on the one-hot grant; all fields are zero with no grant.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            mem_we_o    = mem_we_o | (we_i[i] & gnt_o[i]);
            mem_be_o    = mem_be_o | (be_i[i*BE_W +: BE_W] & {BE_W{gnt_o[i]}});
            mem_addr_o  = mem_addr_o | (addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{gnt_o[i]}});
            mem_wdata_o = mem_wdata_o | (wdata_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gnt_o[i]}});
        end
    end

    assign mem_req_o = active;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= '0;
        end else if (active) begin
            prio_q <= (winner == PRIO_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    // Read-return tracking: one stage per cycle of memory latency.
    logic [MEM_LATENCY-1:0]             rd_valid_q;
    logic [MEM_LATENCY-1:0][PRIO_W-1:0] rd_id_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_valid_q <= '0;
            rd_id_q    <= '0;
        end else begin
            rd_valid_q[0] <= active & ~mem_we_o;
            rd_id_q[0]    <= winner;
            for (int s = 1; s < MEM_LATENCY; s++) begin
                rd_valid_q[s] <= rd_valid_q[s-1];
                rd_id_q[s]    <= rd_id_q[s-1];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            rvalid_o[i] = rst_ni & rd_valid_q[MEM_LATENCY-1]
                        & (rd_id_q[MEM_LATENCY-1] == PRIO_W'(i));
        end
    end

    assign rdata_o = mem_rdata_i;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [N_REQ-1:0][31:0] grant_cnt_q;
    logic [31:0]            stall_cnt_q;
    logic                   stall;

    // One stall per cycle no matter how many requesters are waiting.
    assign stall = rst_ni & (|(req_i & ~gnt_o));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else if (cnt_clear_i) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt_o[i] && (grant_cnt_q[i] != 32'hFFFF_FFFF)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
                end
            end
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign grant_cnt_o = grant_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb/tb_mem_rr_arbiter.sv - randomized self-checking bench for mem_rr_arbiter with a behavioural model

module tb_mem_rr_arbiter;

    localparam int N   = 3;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int BW  = DW / 8;
    localparam int LAT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_ni;
    logic [N-1:0]      req;
    logic [N-1:0]      we;
    logic [N*BW-1:0]   be;
    logic [N*AW-1:0]   addr;
    logic [N*DW-1:0]   wdata;
    logic [N-1:0]      gnt_o;
    logic [N-1:0]      rvalid_o;
    logic [DW-1:0]     rdata_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [BW-1:0]     mem_be_o;
    logic [AW-1:0]     mem_addr_o;
    logic [DW-1:0]     mem_wdata_o;
    logic [DW-1:0]     mem_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
    logic              cnt_clear;
    logic [N*32-1:0]   grant_cnt;
    logic [31:0]       stall_cnt;
`endif

    mem_rr_arbiter #(
        .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_i(req), .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
`ifdef MEM_ARB_PERF_CNT_EN
        .cnt_clear_i(cnt_clear), .grant_cnt_o(grant_cnt), .stall_cnt_o(stall_cnt),
`endif
        .mem_rdata_i(mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] init_word(input int i);
        case (i)
            2:       return 64'hDEAD_BEEF_0000_0010;
            3:       return 64'hCAFE_F00D_0000_0018;
            4:       return 64'h0BAD_C0DE_0000_0020;
            default: return 64'h0;
        endcase
    endfunction

    // Memory of the environment: 16 words, latency-1 read port. Reloaded during reset.
    logic [63:0] ram [16];
    always @(posedge clk) begin
        if (!rst_ni) begin
            for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
        end else if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < BW; b++)
                    if (mem_be_o[b]) ram[mem_addr_o[6:3]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
            end else begin
                mem_rdata <= ram[mem_addr_o[6:3]];
            end
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    typedef struct {
        bit          v;
        int          id;
        logic [63:0] d;
    } ent_t;

    ent_t        pipe[$];
    int          prio_m;
    logic [63:0] shadow [16];
    int          wait_m [N];
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] gcnt_m [N];
    logic [31:0] scnt_m;
`endif

    always @(negedge clk) begin
        int          w;
        logic [N-1:0] eg;
        logic [N-1:0] erv;
        logic [63:0] a;
        logic [63:0] wd;
        logic [7:0]  bb;
        ent_t        e;
        if (!rst_ni) begin
            chk("rst_gnt", 64'(gnt_o), 64'h0);
            chk("rst_req", 64'(mem_req_o), 64'h0);
            chk("rst_we", 64'(mem_we_o), 64'h0);
            chk("rst_be", 64'(mem_be_o), 64'h0);
            chk("rst_addr", mem_addr_o, 64'h0);
            chk("rst_wdata", mem_wdata_o, 64'h0);
            chk("rst_rvalid", 64'(rvalid_o), 64'h0);
            pipe.delete();
            for (int s = 0; s < LAT; s++) begin
                e.v = 1'b0; e.id = 0; e.d = '0;
                pipe.push_back(e);
            end
            prio_m = 0;
            for (int i = 0; i < 16; i++) shadow[i] = init_word(i);
            for (int i = 0; i < N; i++) wait_m[i] = 0;
`ifdef MEM_ARB_PERF_CNT_EN
            for (int i = 0; i < N; i++) gcnt_m[i] = 0;
            scnt_m = 0;
            for (int i = 0; i < N; i++) chk("rst_gcnt", 64'(grant_cnt[i*32 +: 32]), 64'h0);
            chk("rst_scnt", 64'(stall_cnt), 64'h0);
`endif
        end else begin
            // Winner: first request met scanning upward from the priority pointer, wrapping.
            w = -1;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (prio_m + k) % N;
                if (w < 0 && req[j]) w = j;
            end
            eg = '0;
            if (w >= 0) eg[w] = 1'b1;
            chk("gnt", 64'(gnt_o), 64'(eg));
            chk("mem_req", 64'(mem_req_o), 64'(w >= 0));
            a  = (w >= 0) ? addr[w*AW +: AW] : 64'h0;
            wd = (w >= 0) ? wdata[w*DW +: DW] : 64'h0;
            bb = (w >= 0) ? be[w*BW +: BW] : 8'h0;
            chk("mem_we", 64'(mem_we_o), 64'((w >= 0) ? we[w] : 1'b0));
            chk("mem_be", 64'(mem_be_o), 64'(bb));
            chk("mem_addr", mem_addr_o, a);
            chk("mem_wdata", mem_wdata_o, wd);

            erv = '0;
            if (pipe[0].v) erv[pipe[0].id] = 1'b1;
            chk("rvalid", 64'(rvalid_o), 64'(erv));
            if (pipe[0].v) chk("rdata", rdata_o, pipe[0].d);

            for (int i = 0; i < N; i++) begin
                if (req[i] && !gnt_o[i]) begin
                    wait_m[i]++;
                    chk("starve", 64'(wait_m[i] <= N - 1), 64'h1);
                end else begin
                    wait_m[i] = 0;
                end
            end

`ifdef MEM_ARB_PERF_CNT_EN
            for (int i = 0; i < N; i++) chk("gcnt", 64'(grant_cnt[i*32 +: 32]), 64'(gcnt_m[i]));
            chk("scnt", 64'(stall_cnt), 64'(scnt_m));
            if (cnt_clear) begin
                for (int i = 0; i < N; i++) gcnt_m[i] = 0;
                scnt_m = 0;
            end else begin
                if (w >= 0 && gcnt_m[w] != 32'hFFFF_FFFF) gcnt_m[w] = gcnt_m[w] + 1;
                if ((req & ~eg) != 0 && scnt_m != 32'hFFFF_FFFF) scnt_m = scnt_m + 1;
            end
`endif

            // Advance state to what holds after the coming clock edge.
            e.v = 1'b0; e.id = 0; e.d = '0;
            if (w >= 0) begin
                if (we[w]) begin
                    for (int b = 0; b < BW; b++)
                        if (bb[b]) shadow[a[6:3]][b*8 +: 8] = wd[b*8 +: 8];
                end else begin
                    e.v = 1'b1; e.id = w; e.d = shadow[a[6:3]];
                end
                prio_m = (w == N - 1) ? 0 : w + 1;
            end
            void'(pipe.pop_front());
            pipe.push_back(e);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic w_en, input logic [7:0] b,
                           input logic [63:0] ad, input logic [63:0] d);
        we[i]             = w_en;
        be[i*BW +: BW]    = b;
        addr[i*AW +: AW]  = ad;
        wdata[i*DW +: DW] = d;
    endtask

    logic [N-1:0] seq [6];
    logic [N-1:0] gs;

    initial begin
        rst_ni = 1'b0;
        req = '0; we = '0; be = '0; addr = '0; wdata = '0;
`ifdef MEM_ARB_PERF_CNT_EN
        cnt_clear = 1'b0;
`endif
        repeat (3) begin
            @(negedge clk);
            chk("reset_gnt", 64'(gnt_o), 64'h0);
            chk("reset_rvalid", 64'(rvalid_o), 64'h0);
        end
        step();
        rst_ni = 1'b1;

        // All three requesting: strict rotation.
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100;
        seq[3] = 3'b001; seq[4] = 3'b010; seq[5] = 3'b100;
        set_req(0, 1'b0, 8'hFF, 64'h28, 64'h0);
        set_req(1, 1'b0, 8'hFF, 64'h30, 64'h0);
        set_req(2, 1'b0, 8'hFF, 64'h38, 64'h0);
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rr_seq", 64'(gnt_o), 64'(seq[k]));
            step();
        end
        req = '0;
        @(negedge clk);
        step();

        // Single read from requester 2 of preloaded data.
        set_req(2, 1'b0, 8'hFF, 64'h10, 64'h0);
        req = 3'b100;
        @(negedge clk);
        chk("rd2_gnt", 64'(gnt_o), 64'h4);
        step();
        req = '0;
        @(negedge clk);
        chk("rd2_rvalid", 64'(rvalid_o), 64'h4);
        chk("rd2_rdata", rdata_o, 64'hDEAD_BEEF_0000_0010);
        step();

        // Partial write then read-back from requester 0.
        set_req(0, 1'b1, 8'h0F, 64'h8, 64'h1122_3344_5566_7788);
        req = 3'b001;
        @(negedge clk);
        chk("wr_gnt", 64'(gnt_o), 64'h1);
        chk("wr_we", 64'(mem_we_o), 64'h1);
        step();
        set_req(0, 1'b0, 8'hFF, 64'h8, 64'h0);
        @(negedge clk);
        chk("wr_no_rvalid", 64'(rvalid_o), 64'h0);
        chk("rdbk_gnt", 64'(gnt_o), 64'h1);
        step();
        req = '0;
        @(negedge clk);
        chk("rdbk_rvalid", 64'(rvalid_o), 64'h1);
        chk("rdbk_rdata", rdata_o, 64'h0000_0000_5566_7788);
        step();

        // Back-to-back reads from requesters 1 and 2.
        set_req(1, 1'b0, 8'hFF, 64'h18, 64'h0);
        req = 3'b010;
        @(negedge clk);
        chk("b2b_gnt1", 64'(gnt_o), 64'h2);
        step();
        set_req(2, 1'b0, 8'hFF, 64'h20, 64'h0);
        req = 3'b100;
        @(negedge clk);
        chk("b2b_gnt2", 64'(gnt_o), 64'h4);
        chk("b2b_rv1", 64'(rvalid_o), 64'h2);
        chk("b2b_rd1", rdata_o, 64'hCAFE_F00D_0000_0018);
        step();
        req = '0;
        @(negedge clk);
        chk("b2b_rv2", 64'(rvalid_o), 64'h4);
        chk("b2b_rd2", rdata_o, 64'h0BAD_C0DE_0000_0020);
        step();

        // Reset while a read is in flight: the return is dropped and priority restarts at 0.
        set_req(1, 1'b0, 8'hFF, 64'h18, 64'h0);
        req = 3'b010;
        @(negedge clk);
        chk("inflight_gnt", 64'(gnt_o), 64'h2);
        step();
        rst_ni = 1'b0;
        req = '0;
        @(negedge clk);
        chk("inflight_drop", 64'(rvalid_o), 64'h0);
        step();
        rst_ni = 1'b1;
        set_req(2, 1'b0, 8'hFF, 64'h20, 64'h0);
        req = 3'b110;
        @(negedge clk);
        chk("post_rst_rvalid", 64'(rvalid_o), 64'h0);
        chk("post_rst_gnt", 64'(gnt_o), 64'h2);
        step();
        req = '0;
        @(negedge clk);
        step();

`ifdef MEM_ARB_PERF_CNT_EN
        cnt_clear = 1'b1;
        @(negedge clk);
        step();
        cnt_clear = 1'b0;
        req = 3'b111;
        repeat (9) begin
            @(negedge clk);
            step();
        end
        req = '0;
        @(negedge clk);
        for (int i = 0; i < N; i++) chk("perf_gcnt", 64'(grant_cnt[i*32 +: 32]), 64'd3);
        chk("perf_scnt", 64'(stall_cnt), 64'd9);
        step();
        req = 3'b111;
        cnt_clear = 1'b1;
        @(negedge clk);
        step();
        cnt_clear = 1'b0;
        req = '0;
        @(negedge clk);
        for (int i = 0; i < N; i++) chk("clr_gcnt", 64'(grant_cnt[i*32 +: 32]), 64'd0);
        chk("clr_scnt", 64'(stall_cnt), 64'd0);
        step();
`endif

        // Randomized traffic with the hold-until-granted protocol and rare resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            gs = gnt_o;
            step();
            rst_ni = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < N; i++) begin
                if (req[i] && gs[i]) req[i] = 1'b0;
                if (!req[i] && $urandom_range(0, 99) < 55) begin
                    req[i] = 1'b1;
                    set_req(i, ($urandom_range(0, 2) == 0), 8'($urandom),
                            64'($urandom_range(0, 15)) << 3, {$urandom, $urandom});
                end
            end
`ifdef MEM_ARB_PERF_CNT_EN
            cnt_clear = ($urandom_range(0, 99) == 0);
`endif
        end
        rst_ni = 1'b1;
        req = '0;
`ifdef MEM_ARB_PERF_CNT_EN
        cnt_clear = 1'b0;
`endif
        repeat (4) begin
            @(negedge clk);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
